// File: rtl/subneg_ctrl.sv
// subneg_ctrl: instruction sequencer for the SUBNEG core.
// Fetches A, B, C from program ROM, reads mem[A] and mem[B], writes
// mem[B] - mem[A] back to mem[B], and branches to C on a negative result.
// pc_addr and dmem_addr are registers loaded with the value belonging to the
// state being entered, so each state presents its address for its whole
// cycle and holds it through a stall.
module subneg_ctrl #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      HALT_ADDR = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] pc_addr,
  input  logic [WIDTH-1:0] prog_data,
  output logic [WIDTH-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic             dmem_we,
  output logic [WIDTH-1:0] pc,
  output logic             halted
);

  localparam logic [2:0] S_FA   = 3'd0;
  localparam logic [2:0] S_FB   = 3'd1;
  localparam logic [2:0] S_FC   = 3'd2;
  localparam logic [2:0] S_RA   = 3'd3;
  localparam logic [2:0] S_RB   = 3'd4;
  localparam logic [2:0] S_LB   = 3'd5;
  localparam logic [2:0] S_EX   = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;

  logic [2:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] pc_next_seq;
  logic             neg;

  // Subtraction result and sequential-PC candidate.
  always_comb begin
    res         = op_b - op_a;
    neg         = res[WIDTH-1];
    pc_next_seq = pc + WIDTH'(3);
  end

  // Write strobe only in an enabled, non-reset execute cycle, so a stalled
  // or reset-aborted execute never writes.
  assign dmem_we    = en && !rst && (state == S_EX);
  assign dmem_wdata = res;
  assign halted     = (state == S_HALT);

  // Instruction sequencing FSM with registered address outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FA;
      pc        <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      op_a      <= '0;
      op_b      <= '0;
      pc_addr   <= '0;
      dmem_addr <= '0;
    end else if (en) begin
      case (state)
        S_FA: begin
          pc_addr <= pc + WIDTH'(1);
          state   <= S_FB;
        end
        S_FB: begin
          a       <= prog_data;
          pc_addr <= pc + WIDTH'(2);
          state   <= S_FC;
        end
        S_FC: begin
          b         <= prog_data;
          dmem_addr <= a;
          state     <= S_RA;
        end
        S_RA: begin
          c         <= prog_data;
          dmem_addr <= b;
          state     <= S_RB;
        end
        S_RB: begin
          op_a  <= dmem_rdata;
          state <= S_LB;
        end
        S_LB: begin
          op_b  <= dmem_rdata;
          state <= S_EX;
        end
        S_EX: begin
          if (neg) begin
            pc <= c;
            if (c == HALT_ADDR) begin
              state <= S_HALT;
            end else begin
              pc_addr <= c;
              state   <= S_FA;
            end
          end else begin
            pc      <= pc_next_seq;
            pc_addr <= pc_next_seq;
            state   <= S_FA;
          end
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule
